// File: rtl/ppc_types.sv
// Shared types for the result broadcast path: CDB entry layout used by units,
// reservation stations and the CDB arbiter, plus the round-robin pointer step.
package ppc_types;

  localparam int CDB_RS_ID_W = 5;
  localparam int CDB_VALUE_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [CDB_RS_ID_W-1:0] rs_id;
    logic [CDB_VALUE_W-1:0] value;
  } cdb_entry_t;

  // Pointer moves to the slot just past the winner so the winner becomes lowest priority.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Zero latency; produces a one-hot grant and the matching binary index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_j       = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IDX_W'((int'(ptr) + k) % N);
      if (!w_found && req[w_j]) begin
        grant[w_j] = 1'b1;
        grant_idx  = w_j;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of execution-unit results onto the common data bus; one
// transfer per cycle, broadcast registered 1 cycle later. CDB_STALL_COUNT_EN adds stall_count.
module cdb_arbiter
  import ppc_types::*;
#(
  parameter int NUM_UNITS     = 4,
  parameter int OPERAND_WIDTH = 32,
  parameter int RS_ID_WIDTH   = 5
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_UNITS-1:0]                      unit_valid,
  output logic [NUM_UNITS-1:0]                      unit_ready,
  input  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0]     unit_rs_id,
  input  logic [NUM_UNITS-1:0][OPERAND_WIDTH-1:0]   unit_value,
  output logic                                      cdb_valid,
  output logic [RS_ID_WIDTH-1:0]                    cdb_rs_id,
  output logic [OPERAND_WIDTH-1:0]                  cdb_value
`ifdef CDB_STALL_COUNT_EN
  ,
  output logic [15:0]                               stall_count
`endif
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0]     w_req;
  logic [NUM_UNITS-1:0]     w_grant;
  logic [IDX_W-1:0]         w_grant_idx;
  logic                     w_xfer;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic                     r_cdb_valid;
  logic [RS_ID_WIDTH-1:0]   r_cdb_rs_id;
  logic [OPERAND_WIDTH-1:0] r_cdb_value;

  // Masking requests during reset keeps unit_ready low so no requester believes it was accepted.
  assign w_req = rst ? '0 : unit_valid;

  rr_arbiter #(
    .N     (NUM_UNITS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign unit_ready = w_grant;
  assign w_xfer     = |w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= IDX_W'(rr_next(int'(w_grant_idx), NUM_UNITS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_rs_id <= '0;
      r_cdb_value <= '0;
    end else begin
      r_cdb_valid <= w_xfer;
      if (w_xfer) begin
        r_cdb_rs_id <= unit_rs_id[w_grant_idx];
        r_cdb_value <= unit_value[w_grant_idx];
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_rs_id = r_cdb_rs_id;
  assign cdb_value = r_cdb_value;

`ifdef CDB_STALL_COUNT_EN
  logic [15:0] r_stall_count;
  logic        w_stall;

  assign w_stall = |(unit_valid & ~w_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, number of execution-unit result requesters (range 2..8).
REQ-002 SHALL have parameter OPERAND_WIDTH, default 32, result value width.
REQ-003 SHALL have parameter RS_ID_WIDTH, default 5, reservation-station ID width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port unit_valid  in  1 x NUM_UNITS  result request per unit.
REQ-007 SHALL have port unit_ready  out  1 x NUM_UNITS  grant/accept per unit.
REQ-008 SHALL have port unit_rs_id  in  RS_ID_WIDTH x NUM_UNITS  producing RS ID per unit.
REQ-009 SHALL have port unit_value  in  OPERAND_WIDTH x NUM_UNITS  result value per unit.
REQ-010 SHALL have port cdb_valid  out  1  broadcast valid, fanned out by the top level to every operand_valid input of every reservation station.
REQ-011 SHALL have port cdb_rs_id  out  RS_ID_WIDTH  broadcast producer ID.
REQ-012 SHALL have port cdb_value  out  OPERAND_WIDTH  broadcast result.

Function
REQ-013 SHALL transfer from unit i only when unit_valid[i] and unit_ready[i] are high in the same cycle.
REQ-014 SHALL assert at most one unit_ready bit per cycle; unit_ready is combinational from unit_valid and the priority pointer.
REQ-015 SHALL never assert unit_ready[i] while unit_valid[i] is low.
REQ-016 SHALL grant round-robin: first valid unit searching upward from priority pointer rr_ptr, wrapping NUM_UNITS-1 -> 0.
REQ-017 SHALL set rr_ptr to (granted index + 1) mod NUM_UNITS after a transfer; rr_ptr SHALL hold when no transfer occurs.
REQ-018 SHALL register the granted rs_id/value into the cdb output register; cdb_valid, cdb_rs_id and cdb_value SHALL appear exactly 1 cycle after the transfer cycle.
REQ-019 SHALL drive cdb_valid low in any cycle following a cycle with no transfer; cdb_rs_id/cdb_value SHALL hold their previous values then.
REQ-020 SHALL present cdb_valid for exactly one cycle per transfer (broadcast, no back-pressure from consumers).
REQ-021 SHALL sustain one transfer per cycle under continuous requests (throughput 1/cycle, no bubbles).
REQ-022 SHALL require requesters to hold unit_valid and data stable until accepted; the arbiter SHALL not buffer unaccepted requests.
REQ-023 SHALL, with all NUM_UNITS valid continuously, grant each unit exactly once every NUM_UNITS cycles.

Reset
REQ-024 SHALL, while rst is high, force cdb_valid=0, cdb_rs_id=0, cdb_value=0, rr_ptr=0 immediately (asynchronously).
REQ-025 SHALL drive unit_ready all 0 while rst is high; a request pending across reset SHALL be granted afresh from rr_ptr=0 after release.
REQ-026 SHALL discard a transfer in flight when reset asserts; no cdb_valid pulse SHALL follow reset release for it.

Configuration
REQ-027 SHALL, when macro CDB_STALL_COUNT_EN is defined, add output stall_count (16 bits) counting cycles in which at least one unit_valid is high but not granted, saturating at 0xFFFF, reset to 0.
REQ-028 SHALL, without CDB_STALL_COUNT_EN, omit the stall_count port and counter entirely.

Structure
REQ-029 SHALL place typedef cdb_entry_t (valid, rs_id, value) in package ppc_types for reuse by reservation stations and units.
REQ-030 SHALL implement the grant logic as sub-module rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant and grant index).

Verification
REQ-031 SHALL cover: single request, unit 2 valid with rs_id=9 and value=0xDEADBEEF -> unit_ready[2] same cycle; next cycle cdb_valid=1, cdb_rs_id=9, cdb_value=0xDEADBEEF; next cycle cdb_valid=0.
REQ-032 SHALL cover: all 4 units valid for 8 cycles with rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; cdb_valid high 8 consecutive cycles.
REQ-033 SHALL cover: rr_ptr=3, units 0 and 3 valid -> unit 3 granted first, then unit 0, then rr_ptr=1.
REQ-034 SHALL cover: rst asserted mid-cycle during a transfer from unit 1 -> outputs 0 immediately; no cdb_valid after release; rr_ptr=0.
REQ-035 SHALL cover (CDB_STALL_COUNT_EN): 3 units valid for 10 cycles -> stall_count=10; forced 70000 stall cycles -> stall_count=0xFFFF.
REQ-036 SHALL cover: idle with no unit_valid for 5 cycles -> unit_ready all 0, cdb_valid 0, rr_ptr unchanged.
